// File: rtl/jogo_sequencia_param.sv
// Parametrised memory-sequence game core: progressive rounds replaying ROM entries 1 << (i % N).
// Optional per-jogada timer is compiled in when the JOGO_TIMEOUT_EN macro is defined.
module jogo_sequencia_param #(
  parameter int unsigned N       = 4,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 3000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     iniciar,
  input  logic [N-1:0]             chaves,
  output logic                     acertou,
  output logic                     errou,
  output logic                     timeout,
  output logic                     pronto,
  output logic [N-1:0]             leds,
  output logic [$clog2(DEPTH)-1:0] db_rodada,
  output logic [$clog2(DEPTH)-1:0] db_contagem,
  output logic [3:0]               db_estado,
  output logic                     db_tem_jogada
);

  localparam int unsigned CW = $clog2(DEPTH);

  if (N < 1 || DEPTH < 2 || TIMEOUT < 2) begin : g_param_check
    $error("jogo_sequencia_param: needs N >= 1, DEPTH >= 2, TIMEOUT >= 2");
  end

  typedef enum logic [3:0] {
    S_INICIAL     = 4'h0,
    S_PREPARACAO  = 4'h1,
    S_ESPERA      = 4'h2,
    S_REGISTRA    = 4'h3,
    S_COMPARA     = 4'h4,
    S_PROX_JOGADA = 4'h5,
    S_PROX_RODADA = 4'h6,
    S_FIM_ACERTO  = 4'hA,
    S_FIM_ERRO    = 4'hE,
    S_FIM_TIMEOUT = 4'hF
  } estado_t;

  estado_t        estado_q, estado_d;
  logic [CW-1:0]  rodada_q, rodada_d;
  logic [CW-1:0]  contagem_q, contagem_d;
  logic [N-1:0]   jogada_q, jogada_d;
  logic           prev_q, prev_d;
  logic           tem_jogada_q, tem_jogada_d;
  logic           acertou_q, acertou_d;
  logic           errou_q, errou_d;
  logic           pronto_q, pronto_d;
  logic           tem_jogada_c;
  logic           match_c;
  logic           ultima_c;
  logic           fim_seq_c;

  // Sequence ROM: one-hot entry cycling through the N buttons.
  function automatic logic [N-1:0] rom_entry(input logic [CW-1:0] idx);
    return N'(1) << (idx % N);
  endfunction

  assign tem_jogada_c = (|chaves) & ~prev_q;
  assign match_c      = (jogada_q == rom_entry(contagem_q));
  assign ultima_c     = (contagem_q == rodada_q);
  assign fim_seq_c    = (rodada_q == CW'(DEPTH - 1));

`ifdef JOGO_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT);

  logic [TW-1:0] timer_q, timer_d;
  logic          timeout_q, timeout_d;
  logic          expirou_c;

  assign expirou_c = (timer_q == TW'(TIMEOUT - 1));
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

  // Next-state, datapath and registered-output computation.
  always_comb begin
    estado_d     = estado_q;
    rodada_d     = rodada_q;
    contagem_d   = contagem_q;
    jogada_d     = jogada_q;
    prev_d       = |chaves;
    tem_jogada_d = tem_jogada_c;

    case (estado_q)
      S_INICIAL: begin
        if (iniciar) estado_d = S_PREPARACAO;
      end
      S_PREPARACAO: begin
        rodada_d   = '0;
        contagem_d = '0;
        jogada_d   = '0;
        estado_d   = S_ESPERA;
      end
      S_ESPERA: begin
        if (tem_jogada_c) begin
          jogada_d = chaves;
          estado_d = S_REGISTRA;
        end
`ifdef JOGO_TIMEOUT_EN
        else if (expirou_c) begin
          estado_d = S_FIM_TIMEOUT;
        end
`endif
      end
      S_REGISTRA: estado_d = S_COMPARA;
      S_COMPARA: begin
        if (!match_c)       estado_d = S_FIM_ERRO;
        else if (!ultima_c) estado_d = S_PROX_JOGADA;
        else if (fim_seq_c) estado_d = S_FIM_ACERTO;
        else                estado_d = S_PROX_RODADA;
      end
      S_PROX_JOGADA: begin
        contagem_d = contagem_q + CW'(1);
        estado_d   = S_ESPERA;
      end
      S_PROX_RODADA: begin
        rodada_d   = rodada_q + CW'(1);
        contagem_d = '0;
        estado_d   = S_ESPERA;
      end
      S_FIM_ACERTO, S_FIM_ERRO, S_FIM_TIMEOUT: begin
        if (iniciar) estado_d = S_PREPARACAO;
      end
      default: estado_d = S_INICIAL;
    endcase

    acertou_d = (estado_d == S_FIM_ACERTO);
    errou_d   = (estado_d == S_FIM_ERRO);
    pronto_d  = (estado_d == S_FIM_ACERTO) || (estado_d == S_FIM_ERRO) ||
                (estado_d == S_FIM_TIMEOUT);

`ifdef JOGO_TIMEOUT_EN
    // Timer restarts on every entry to espera and only runs while waiting.
    timer_d   = (estado_q == S_ESPERA) ? timer_q + TW'(1) : '0;
    timeout_d = (estado_d == S_FIM_TIMEOUT);
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q     <= S_INICIAL;
      rodada_q     <= '0;
      contagem_q   <= '0;
      jogada_q     <= '0;
      prev_q       <= 1'b0;
      tem_jogada_q <= 1'b0;
      acertou_q    <= 1'b0;
      errou_q      <= 1'b0;
      pronto_q     <= 1'b0;
`ifdef JOGO_TIMEOUT_EN
      timer_q      <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      estado_q     <= estado_d;
      rodada_q     <= rodada_d;
      contagem_q   <= contagem_d;
      jogada_q     <= jogada_d;
      prev_q       <= prev_d;
      tem_jogada_q <= tem_jogada_d;
      acertou_q    <= acertou_d;
      errou_q      <= errou_d;
      pronto_q     <= pronto_d;
`ifdef JOGO_TIMEOUT_EN
      timer_q      <= timer_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign acertou       = acertou_q;
  assign errou         = errou_q;
  assign pronto        = pronto_q;
  assign leds          = jogada_q;
  assign db_rodada     = rodada_q;
  assign db_contagem   = contagem_q;
  assign db_estado     = estado_q;
  assign db_tem_jogada = tem_jogada_q;

endmodule

// File: tb/tb_jogo_sequencia_param.sv
// Self-checking bench for jogo_sequencia_param (N=4, DEPTH=4, TIMEOUT=20) with a game-rule model.
module tb_jogo_sequencia_param;

  localparam int N       = 4;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 20;
  localparam int CW      = $clog2(DEPTH);

`ifdef JOGO_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          iniciar;
  logic [N-1:0]  chaves;
  logic          acertou, errou, timeout, pronto, db_tem_jogada;
  logic [N-1:0]  leds;
  logic [CW-1:0] db_rodada, db_contagem;
  logic [3:0]    db_estado;

  jogo_sequencia_param #(.N(N), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
    .acertou(acertou), .errou(errou), .timeout(timeout), .pronto(pronto),
    .leds(leds), .db_rodada(db_rodada), .db_contagem(db_contagem),
    .db_estado(db_estado), .db_tem_jogada(db_tem_jogada)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Game-rule model: round, position within round, result (0 playing, 1 win, 2 error).
  int m_rodada, m_contagem, m_res;

  function automatic logic [N-1:0] seq_entry(int i);
    logic [N-1:0] v;
    v = 1;
    return v << (i % N);
  endfunction

  function automatic logic [3:0] exp_estado();
    if (m_res == 1) return 4'hA;
    if (m_res == 2) return 4'hE;
    return 4'h2;
  endfunction

  task automatic tick(int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic model_play(logic [N-1:0] v);
    if (m_res != 0) return;
    if (v != seq_entry(m_contagem)) m_res = 2;
    else if (m_contagem < m_rodada) m_contagem++;
    else if (m_rodada == DEPTH - 1) m_res = 1;
    else begin
      m_rodada++;
      m_contagem = 0;
    end
  endtask

  task automatic start_game();
    iniciar = 1'b1;
    tick(1);
    iniciar = 1'b0;
    tick(1);
    m_rodada = 0;
    m_contagem = 0;
    m_res = 0;
  endtask

  task automatic jogar(logic [N-1:0] v, int hold, int gap, logic ini);
    chaves = v;
    iniciar = ini;
    tick(1);
    iniciar = 1'b0;
    tick(hold - 1);
    chaves = '0;
    tick(gap);
    model_play(v);
  endtask

  task automatic play_win();
    for (int r = 0; r < DEPTH; r++)
      for (int j = 0; j <= r; j++)
        jogar(seq_entry(j), 5, 5, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1; iniciar = 1'b0; chaves = '0;
    tick(2);
    reset = 1'b0;
    tick(10);
    checks++; if (db_estado !== 4'h0) begin errors++; $display("FAIL reset_estado: got %0h expected 0", db_estado); end
    checks++; if (pronto !== 1'b0) begin errors++; $display("FAIL reset_pronto: got %b expected 0", pronto); end
    checks++; if (leds !== 4'b0000) begin errors++; $display("FAIL reset_leds: got %b expected 0000", leds); end
    checks++; if ({acertou, errou, timeout, db_tem_jogada} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {acertou, errou, timeout, db_tem_jogada}); end
    checks++; if ({db_rodada, db_contagem} !== '0) begin
      errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", db_rodada, db_contagem); end
  endtask

  task automatic test_win();
    start_game();
    play_win();
    checks++; if (acertou !== 1'b1) begin errors++; $display("FAIL win_acertou: got %b expected 1", acertou); end
    checks++; if (pronto !== 1'b1) begin errors++; $display("FAIL win_pronto: got %b expected 1", pronto); end
    checks++; if (db_estado !== 4'hA) begin errors++; $display("FAIL win_estado: got %0h expected a", db_estado); end
    checks++; if (db_rodada !== CW'(DEPTH - 1)) begin errors++; $display("FAIL win_rodada: got %0d expected %0d", db_rodada, DEPTH - 1); end
    checks++; if (leds !== seq_entry(DEPTH - 1)) begin errors++; $display("FAIL win_leds: got %b expected %b", leds, seq_entry(DEPTH - 1)); end
    checks++; if ({errou, timeout} !== 2'b00) begin errors++; $display("FAIL win_other_flags: got %b expected 00", {errou, timeout}); end
  endtask

  task automatic test_error();
    start_game();
    jogar(4'b0001, 5, 5, 1'b0);
    jogar(4'b0001, 5, 5, 1'b0);
    chaves = 4'b0100;
    tick(1);
    chaves = '0;
    tick(1);
    checks++; if (db_estado !== 4'h4 || errou !== 1'b0) begin
      errors++; $display("FAIL error_compara: got estado %0h errou %b expected 4/0", db_estado, errou); end
    tick(1);
    checks++; if (errou !== 1'b1) begin errors++; $display("FAIL error_latency: got %b expected 1", errou); end
    checks++; if (db_estado !== 4'hE || pronto !== 1'b1) begin
      errors++; $display("FAIL error_estado: got %0h/%b expected e/1", db_estado, pronto); end
    checks++; if (leds !== 4'b0100) begin errors++; $display("FAIL error_leds: got %b expected 0100", leds); end
    checks++; if (db_rodada !== CW'(1)) begin errors++; $display("FAIL error_rodada: got %0d expected 1", db_rodada); end
    tick(4);
    checks++; if (errou !== 1'b1 || acertou !== 1'b0) begin
      errors++; $display("FAIL error_hold: got errou %b acertou %b expected 1/0", errou, acertou); end
  endtask

  task automatic test_restart();
    iniciar = 1'b1;
    tick(1);
    iniciar = 1'b0;
    checks++; if (db_estado !== 4'h1 || errou !== 1'b0 || pronto !== 1'b0) begin
      errors++; $display("FAIL restart_prep: got estado %0h errou %b pronto %b expected 1/0/0", db_estado, errou, pronto); end
    tick(1);
    checks++; if (db_rodada !== '0 || db_contagem !== '0 || leds !== '0) begin
      errors++; $display("FAIL restart_clear: got %0d/%0d/%b expected 0/0/0000", db_rodada, db_contagem, leds); end
    m_rodada = 0; m_contagem = 0; m_res = 0;
    play_win();
    checks++; if (acertou !== 1'b1 || db_estado !== 4'hA) begin
      errors++; $display("FAIL restart_win: got acertou %b estado %0h expected 1/a", acertou, db_estado); end
  endtask

  task automatic test_timeout();
    reset = 1'b1; tick(1); reset = 1'b0;
    start_game();
    chaves = 4'b0001;
    tick(1);
    chaves = '0;
    tick(TIMEOUT + 2);
    checks++; if (db_estado !== 4'h2 || timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_early: got estado %0h timeout %b expected 2/0", db_estado, timeout); end
    tick(1);
    checks++; if (timeout !== TO_EN) begin errors++; $display("FAIL timeout_flag: got %b expected %b", timeout, TO_EN); end
    checks++; if (db_estado !== (TO_EN ? 4'hF : 4'h2) || pronto !== TO_EN) begin
      errors++; $display("FAIL timeout_estado: got %0h/%b expected %0h/%b", db_estado, pronto, TO_EN ? 4'hF : 4'h2, TO_EN); end
    tick(30);
    checks++; if (timeout !== TO_EN || db_rodada !== CW'(1)) begin
      errors++; $display("FAIL timeout_hold: got %b rodada %0d expected %b/1", timeout, db_rodada, TO_EN); end
  endtask

  task automatic test_hold_once();
    reset = 1'b1; tick(1); reset = 1'b0;
    start_game();
    jogar(4'b0001, 5, 5, 1'b0);
    chaves = 4'b0001;
    tick(30);
    checks++; if (db_contagem !== CW'(1) || db_rodada !== CW'(1)) begin
      errors++; $display("FAIL hold_count: got contagem %0d rodada %0d expected 1/1", db_contagem, db_rodada); end
    checks++; if (db_estado !== (TO_EN ? 4'hF : 4'h2)) begin
      errors++; $display("FAIL hold_estado: got %0h expected %0h", db_estado, TO_EN ? 4'hF : 4'h2); end
    checks++; if (db_tem_jogada !== 1'b0 || errou !== 1'b0) begin
      errors++; $display("FAIL hold_edge: got tem %b errou %b expected 0/0", db_tem_jogada, errou); end
    chaves = '0;
    tick(2);
  endtask

  task automatic test_reset_espera();
    reset = 1'b1; tick(1); reset = 1'b0;
    start_game();
    jogar(4'b0001, 3, 5, 1'b0);
    checks++; if (db_estado !== 4'h2 || leds !== 4'b0001) begin
      errors++; $display("FAIL rst_esp_pre: got %0h/%b expected 2/0001", db_estado, leds); end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checks++; if ({db_estado, leds, db_rodada, db_contagem} !== '0) begin
      errors++; $display("FAIL rst_esp_state: got %0h/%b/%0d/%0d expected all 0", db_estado, leds, db_rodada, db_contagem); end
    checks++; if ({acertou, errou, timeout, pronto, db_tem_jogada} !== 5'b0) begin
      errors++; $display("FAIL rst_esp_flags: got %b expected 00000", {acertou, errou, timeout, pronto, db_tem_jogada}); end
    tick(3);
    checks++; if (db_estado !== 4'h0) begin errors++; $display("FAIL rst_esp_idle: got %0h expected 0", db_estado); end
  endtask

  task automatic test_random();
    logic [N-1:0] v;
    int err_at, n;
    for (int g = 0; g < 20; g++) begin
      reset = 1'b1; tick(1); reset = 1'b0;
      start_game();
      err_at = $urandom_range(0, DEPTH * (DEPTH + 1) / 2);
      n = 0;
      while (m_res == 0) begin
        v = seq_entry(m_contagem);
        if (n == err_at) begin
          do v = N'($urandom_range(1, (1 << N) - 1)); while (v == seq_entry(m_contagem));
        end
        jogar(v, $urandom_range(1, 5), $urandom_range(4, 6), 1'($urandom_range(0, 1)));
        n++;
        checks++; if (db_rodada !== CW'(m_rodada) || db_contagem !== CW'(m_contagem)) begin
          errors++; $display("FAIL rand_counters g%0d n%0d: got %0d/%0d expected %0d/%0d", g, n, db_rodada, db_contagem, m_rodada, m_contagem); end
        checks++; if (leds !== v) begin errors++; $display("FAIL rand_leds g%0d n%0d: got %b expected %b", g, n, leds, v); end
        checks++; if (db_estado !== exp_estado()) begin
          errors++; $display("FAIL rand_estado g%0d n%0d: got %0h expected %0h", g, n, db_estado, exp_estado()); end
        checks++; if ({acertou, errou, pronto, timeout} !== {m_res == 1, m_res == 2, m_res != 0, 1'b0}) begin
          errors++; $display("FAIL rand_flags g%0d n%0d: got %b expected %b", g, n, {acertou, errou, pronto, timeout}, {m_res == 1, m_res == 2, m_res != 0, 1'b0}); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_win();
    test_error();
    test_restart();
    test_timeout();
    test_hold_once();
    test_reset_espera();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
